// File: rtl/aq_shift_reg.sv
// A/Q/q_m1 shift-register datapath for shift-add and Booth multipliers.
// A is loadable from an external adder; {A,Q,q_m1} shifts right with a serial bit into A's MSB.
module aq_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic [WIDTH-1:0]               q_load,
  input  logic                           a_we,
  input  logic [WIDTH-1:0]               a_load,
  input  logic                           shift,
  input  logic                           shift_in,
  output logic [WIDTH-1:0]               a_out,
  output logic [WIDTH-1:0]               q_out,
  output logic                           q_m1,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(WIDTH+1)-1:0]     count
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH-1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             m1_q, m1_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] a_src_s;

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m1_q    <= 1'b0;
      cnt_q   <= CNT_ZERO;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m1_q    <= m1_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: start wins, then fused/plain shift, then A write
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m1_d    = m1_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    a_src_s = a_we ? a_load : a_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = '0;
          q_d     = q_load;
          m1_d    = 1'b0;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (start) begin
          state_d = RUN;
          a_d     = '0;
          q_d     = q_load;
          m1_d    = 1'b0;
          cnt_d   = CNT_ZERO;
        end else if (shift) begin
          // a_src_s already carries the adder result for a fused add+shift
          {a_d, q_d} = {shift_in, a_src_s, q_q[WIDTH-1:1]};
          m1_d       = q_q[0];
          cnt_d      = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end else begin
          a_d = a_src_s;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign a_out = a_q;
  assign q_out = q_q;
  assign q_m1  = m1_q;
  assign busy  = (state_q == RUN);
  assign done  = done_q;
  assign count = cnt_q;

endmodule

// File: tb/tb_aq_shift_reg.sv
// Directed bench for aq_shift_reg (WIDTH=4) with hand-computed expected values.
module tb_aq_shift_reg;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] q_load;
  logic       a_we;
  logic [3:0] a_load;
  logic       shift;
  logic       shift_in;
  logic [3:0] a_out;
  logic [3:0] q_out;
  logic       q_m1;
  logic       busy;
  logic       done;
  logic [2:0] count;

  int n_vec = 0;
  int n_bad = 0;

  aq_shift_reg #(.WIDTH(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .q_load   (q_load),
    .a_we     (a_we),
    .a_load   (a_load),
    .shift    (shift),
    .shift_in (shift_in),
    .a_out    (a_out),
    .q_out    (q_out),
    .q_m1     (q_m1),
    .busy     (busy),
    .done     (done),
    .count    (count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] ea, input logic [3:0] eq,
                         input logic em1, input logic eb, input logic ed, input logic [2:0] ec);
    chk({tag, ".a"},     32'(a_out), 32'(ea));
    chk({tag, ".q"},     32'(q_out), 32'(eq));
    chk({tag, ".q_m1"},  32'(q_m1),  32'(em1));
    chk({tag, ".busy"},  32'(busy),  32'(eb));
    chk({tag, ".done"},  32'(done),  32'(ed));
    chk({tag, ".count"}, 32'(count), 32'(ec));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    start = 1'b0; a_we = 1'b0; shift = 1'b0; shift_in = 1'b0;
    a_load = 4'b0000; q_load = 4'b0000;
  endtask

  initial begin
    reset = 1'b1;
    idle_in();
    tick();
    tick();
    chk_all("reset_hold", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    reset = 1'b0;

    // Idle after reset ignores shift/a_we
    a_we = 1'b1; a_load = 4'b1111; shift = 1'b1; shift_in = 1'b1;
    tick();
    chk_all("post_reset_idle", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0);

    // Start with q_load=1011
    idle_in();
    start = 1'b1; q_load = 4'b1011; a_we = 1'b1; a_load = 4'b1111; shift = 1'b1;
    tick();
    chk_all("start", 4'b0000, 4'b1011, 1'b0, 1'b1, 1'b0, 3'd0);

    // Plain shift
    idle_in();
    shift = 1'b1; shift_in = 1'b0;
    tick();
    chk_all("plain_shift", 4'b0000, 4'b0101, 1'b1, 1'b1, 1'b0, 3'd1);

    // A write only
    idle_in();
    a_we = 1'b1; a_load = 4'b1001;
    tick();
    chk_all("a_write", 4'b1001, 4'b0101, 1'b1, 1'b1, 1'b0, 3'd1);

    // Restart then fused op from A=0000, Q=0101
    idle_in();
    start = 1'b1; q_load = 4'b0101;
    tick();
    idle_in();
    a_we = 1'b1; a_load = 4'b0110; shift = 1'b1; shift_in = 1'b0;
    tick();
    chk_all("fused", 4'b0011, 4'b0010, 1'b1, 1'b1, 1'b0, 3'd1);

    // Unsigned 3x5 shift-add
    idle_in();
    start = 1'b1; q_load = 4'b0101;
    tick();
    idle_in();
    a_we = 1'b1; a_load = 4'b0011; shift = 1'b1; shift_in = 1'b0;   // Q0=1: 0+3
    tick();
    chk_all("mul_s1", 4'b0001, 4'b1010, 1'b1, 1'b1, 1'b0, 3'd1);
    idle_in();
    shift = 1'b1; shift_in = 1'b0;                                  // Q0=0
    tick();
    chk_all("mul_s2", 4'b0000, 4'b1101, 1'b0, 1'b1, 1'b0, 3'd2);
    idle_in();
    a_we = 1'b1; a_load = 4'b0011; shift = 1'b1; shift_in = 1'b0;   // Q0=1: 0+3
    tick();
    chk_all("mul_s3", 4'b0001, 4'b1110, 1'b1, 1'b1, 1'b0, 3'd3);
    idle_in();
    shift = 1'b1; shift_in = 1'b0;                                  // Q0=0, last shift
    tick();
    chk_all("mul_done", 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1, 3'd4);

    // done is a single-cycle pulse; idle hold against shift and a_we
    idle_in();
    a_we = 1'b1; a_load = 4'b1010; shift = 1'b1; shift_in = 1'b1;
    tick();
    chk_all("idle_hold1", 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0, 3'd4);
    shift = 1'b0;
    tick();
    chk_all("idle_hold2", 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0, 3'd4);

    // Abort by start at count=2
    idle_in();
    start = 1'b1; q_load = 4'b1011;
    tick();
    idle_in();
    shift = 1'b1; shift_in = 1'b1;
    tick();
    tick();
    chk_all("pre_abort", 4'b1100, 4'b0010, 1'b1, 1'b1, 1'b0, 3'd2);
    idle_in();
    start = 1'b1; q_load = 4'b0110; shift = 1'b1;
    tick();
    chk_all("abort_start", 4'b0000, 4'b0110, 1'b0, 1'b1, 1'b0, 3'd0);

    // Reset asynchronously at count=2, checked before the next edge
    idle_in();
    shift = 1'b1; shift_in = 1'b1;
    tick();
    tick();
    chk_all("pre_reset", 4'b1100, 4'b0001, 1'b1, 1'b1, 1'b0, 3'd2);
    #2;
    reset = 1'b1;
    #1;
    chk_all("async_reset", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    start = 1'b1; q_load = 4'b1111;
    tick();
    chk_all("reset_over_start", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    idle_in();
    reset = 1'b0;
    shift = 1'b1; a_we = 1'b1; a_load = 4'b0111;
    tick();
    chk_all("reset_release", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/aq_shift_reg.md
AQ_SHIFT_REG -- requirements
Module: aq_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, which sets the bit width of the A and Q registers (legal range 2..32).
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: begins an operation by loading Q and clearing A.
REQ-005 The block SHALL have port q_load, input, WIDTH bits: operand captured into Q on start.
REQ-006 The block SHALL have port a_we, input, 1 bit: write enable for A while busy.
REQ-007 The block SHALL have port a_load, input, WIDTH bits: value written into A (adder result) when a_we.
REQ-008 The block SHALL have port shift, input, 1 bit: shift the {A,Q,q_m1} chain right by one while busy.
REQ-009 The block SHALL have port shift_in, input, 1 bit: serial bit entering A MSB on shift (carry or sign, chosen externally).
REQ-010 The block SHALL have port a_out, output, WIDTH bits: the A register.
REQ-011 The block SHALL have port q_out, output, WIDTH bits: the Q register.
REQ-012 The block SHALL have port q_m1, output, 1 bit: the extra bit right of Q LSB, for Booth decoding.
REQ-013 The block SHALL have port busy, output, 1 bit: high while the operation is in progress.
REQ-014 The block SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-015 The block SHALL have port count, output, clog2(WIDTH+1) bits: number of shifts performed so far.

Function
REQ-016 On start, the block SHALL set A=0, Q=q_load, q_m1=0, count=0, busy=1 and done=0 at the next edge, regardless of busy, a_we or shift.
REQ-017 When start=1 while busy=1, the block SHALL abort the running operation and restart it per REQ-016.
REQ-018 When busy=1 with a_we=1 and shift=0, the block SHALL set A=a_load and leave Q, q_m1 and count unchanged.
REQ-019 When busy=1 with shift=1 and a_we=0, the block SHALL form {shift_in,A,Q} and load its upper 2*WIDTH bits into {A,Q}, and SHALL set q_m1 to the old Q[0] and count=count+1.
REQ-020 When busy=1 with a_we=1 and shift=1, the block SHALL perform a fused operation: shift per REQ-019 using a_load in place of the current A, all within one edge.
REQ-021 When busy=0, the block SHALL ignore a_we and shift, and A, Q, q_m1 and count SHALL hold; the result remains readable.
REQ-022 On the edge that registers the WIDTH-th shift, the block SHALL set busy=0, set done=1 and set count=WIDTH.
REQ-023 The block SHALL deassert done on the following edge unless that edge also completes an operation; done is never high for 2 consecutive cycles from a single operation.
REQ-024 The block SHALL never let count exceed WIDTH or wrap around.
REQ-025 Every output SHALL be driven directly from a register, with no combinational path from inputs to outputs.
REQ-026 The block SHALL have exactly two states, IDLE (busy=0) and RUN (busy=1), with these transitions only:
- IDLE->RUN on start.
- RUN->IDLE on the WIDTH-th shift.
- RUN->RUN on start (restart).

Reset
REQ-027 While reset=1, the block SHALL immediately and asynchronously set A=0, Q=0, q_m1=0, count=0, busy=0 and done=0, and hold them so.
REQ-028 Reset SHALL override start and all other inputs, including assertion in mid-operation.
REQ-029 After reset deasserts, the block SHALL be in IDLE and respond only to start.

Verification
REQ-030 The bench SHALL cover these directed scenarios with WIDTH=4:
- Start: start with q_load=1011 -> next cycle A=0000, Q=1011, q_m1=0, busy=1, count=0.
- Plain shift: from that state, shift=1, shift_in=0 -> A=0000, Q=0101, q_m1=1, count=1.
- Fused: A=0000, Q=0101; a_we=1, a_load=0110, shift=1, shift_in=0 -> A=0011, Q=0010, q_m1=1.
- Unsigned 3x5 (shift-add, carry into shift_in): q_load=0101, add 0011 when Q[0]=1, four shifts -> {A,Q}=0000_1111; done high exactly one cycle; busy low; count=4.
- Idle hold: after done, shift and a_we pulsed -> A, Q and count unchanged.
- Abort: start at count=2 -> A=0, Q=new q_load, count=0. Reset at count=2 -> all outputs 0 asynchronously, before the next edge.
